// File: rtl/fetch_pc_unit.sv
// Fetch program counter with prioritised redirects and a valid/ready imem request.
// Optional FETCH_PC_ALIGN_CHECK_EN: align redirect targets and flag misaligned ones.
module fetch_pc_unit #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INST_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'('h100)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              exc_valid,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              imem_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_kill,
    output logic              redirect_pend,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
`ifdef FETCH_PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic              redir;
    logic [ADDR_W-1:0] raw_tgt;
    logic [ADDR_W-1:0] tgt;
    logic              mis_raw;
    logic              req_int;
    logic              accept;
    logic              blocked;
    logic              kill;

    // Pick the redirect target: exception beats jump beats branch.
    always_comb begin
        redir   = exc_valid | jump_valid | branch_taken;
        raw_tgt = branch_addr;
        if (jump_valid) begin
            raw_tgt = jump_addr;
        end
        if (exc_valid) begin
            raw_tgt = EXC_VEC;
        end
`ifdef FETCH_PC_ALIGN_CHECK_EN
        tgt     = raw_tgt & ~LOW_MASK;
        mis_raw = |(raw_tgt & LOW_MASK);
`else
        tgt     = raw_tgt;
        mis_raw = 1'b0;
`endif
    end

    // Next state, next pc and pending-redirect bookkeeping.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        kill        = 1'b0;
        req_int     = 1'b0;

        unique case (state_q)
            BOOT:    req_int = 1'b0;
            RUN:     req_int = ~stall;
            HOLD:    req_int = 1'b1;
            default: req_int = 1'b0;
        endcase

        accept  = req_int & imem_ready;
        blocked = req_int & ~imem_ready;

        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = blocked ? HOLD : RUN;
            HOLD:    state_d = blocked ? HOLD : RUN;
            default: state_d = BOOT;
        endcase

        // An outstanding request must keep its address, so redirects park.
        if (blocked) begin
            if (redir) begin
                pend_addr_d = tgt;
                pend_d      = 1'b1;
            end
        end else if (redir) begin
            pc_d   = tgt;
            pend_d = 1'b0;
            kill   = accept;
        end else if (accept && pend_q) begin
            pc_d   = pend_addr_q;
            pend_d = 1'b0;
            kill   = 1'b1;
        end else if (accept) begin
            pc_d = pc_q + STEP;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign imem_req      = req_int & ~reset;
    assign imem_kill     = kill & ~reset;
    assign misalign_err  = mis_raw & redir & ~reset;
    assign pc            = pc_q;
    assign redirect_pend = pend_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: 32-bit main instance plus an
// 8-bit instance used to observe address wrap-around.
module tb_fetch_pc_unit;

`ifdef FETCH_PC_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        exc_valid;
    logic        jump_valid;
    logic [31:0] jump_addr;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic        imem_kill;
    logic        redirect_pend;
    logic        misalign_err;

    logic        req8;
    logic [7:0]  pc8;
    logic        kill8;
    logic        pend8;
    logic        mis8;

    typedef struct {
        int          id;
        logic        req;
        logic [31:0] pc;
        logic        kill;
        logic        pend;
        logic        mis;
        logic        c8;
        logic [7:0]  pc8;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   id    = 0;
    logic c8_en = 1'b0;
    logic [7:0] c8_pc = '0;

    fetch_pc_unit #(
        .ADDR_W(32), .INST_BYTES(4),
        .RESET_VEC(32'h0), .EXC_VEC(32'h100)
    ) u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .exc_valid(exc_valid), .jump_valid(jump_valid),
        .jump_addr(jump_addr), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_ready(imem_ready),
        .imem_req(imem_req), .pc(pc), .imem_kill(imem_kill),
        .redirect_pend(redirect_pend), .misalign_err(misalign_err)
    );

    fetch_pc_unit #(
        .ADDR_W(8), .INST_BYTES(4),
        .RESET_VEC(8'h0), .EXC_VEC(8'h10)
    ) u_dut8 (
        .clk(clk), .reset(reset), .stall(stall),
        .exc_valid(exc_valid), .jump_valid(jump_valid),
        .jump_addr(jump_addr[7:0]), .branch_taken(branch_taken),
        .branch_addr(branch_addr[7:0]), .imem_ready(imem_ready),
        .imem_req(req8), .pc(pc8), .imem_kill(kill8),
        .redirect_pend(pend8), .misalign_err(mis8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic stl,
                        input logic ex, input logic jv,
                        input logic [31:0] ja, input logic bt,
                        input logic [31:0] ba, input logic rdy,
                        input logic e_req, input logic [31:0] e_pc,
                        input logic e_kill, input logic e_pend,
                        input logic e_mis);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        stall        = stl;
        exc_valid    = ex;
        jump_valid   = jv;
        jump_addr    = ja;
        branch_taken = bt;
        branch_addr  = ba;
        imem_ready   = rdy;
        e.id   = id;
        e.req  = e_req;
        e.pc   = e_pc;
        e.kill = e_kill;
        e.pend = e_pend;
        e.mis  = e_mis;
        e.c8   = c8_en;
        e.pc8  = c8_pc;
        sb.push_back(e);
        id++;
    endtask

    // Compare the current cycle's outputs mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("c%0d_req", e.id), 32'(imem_req), 32'(e.req));
            chk($sformatf("c%0d_pc", e.id), pc, e.pc);
            chk($sformatf("c%0d_kill", e.id), 32'(imem_kill), 32'(e.kill));
            chk($sformatf("c%0d_pend", e.id),
                32'(redirect_pend), 32'(e.pend));
            chk($sformatf("c%0d_mis", e.id), 32'(misalign_err), 32'(e.mis));
            if (e.c8) begin
                chk($sformatf("c%0d_pc8", e.id), 32'(pc8), 32'(e.pc8));
                chk($sformatf("c%0d_req8", e.id), 32'(req8), 32'(e.req));
                chk($sformatf("c%0d_kill8", e.id), 32'(kill8), 32'(e.kill));
                chk($sformatf("c%0d_pend8", e.id), 32'(pend8), 32'(e.pend));
                chk($sformatf("c%0d_mis8", e.id), 32'(mis8), 32'(1'b0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=0", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a42;
        reset = 1'b1; stall = 1'b0; exc_valid = 1'b0;
        jump_valid = 1'b0; jump_addr = '0;
        branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b0;
        @(posedge clk);
        a42 = ALN ? 32'h40 : 32'h42;
        //   rst stl ex jv ja       bt ba      rdy req pc      k p m
        tick(1, 0, 0, 0, 32'h0,   0, 32'h0,   1,  0, 32'h0,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  0, 32'h0,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h0,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h4,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h8,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'hc,   0, 0, 0);
        // outstanding request held through stall
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   0,  1, 32'h10,  0, 0, 0);
        tick(0, 1, 0, 0, 32'h0,   0, 32'h0,   0,  1, 32'h10,  0, 0, 0);
        tick(0, 1, 0, 0, 32'h0,   0, 32'h0,   0,  1, 32'h10,  0, 0, 0);
        tick(0, 1, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h10,  0, 0, 0);
        tick(0, 1, 0, 0, 32'h0,   0, 32'h0,   1,  0, 32'h14,  0, 0, 0);
        // redirects parked while held, newest wins
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   0,  1, 32'h14,  0, 0, 0);
        tick(0, 0, 0, 1, 32'h40,  0, 32'h0,   0,  1, 32'h14,  0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   1, 32'h80,  0,  1, 32'h14,  0, 1, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h14,  1, 1, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h80,  0, 0, 0);
        // all sources at once: exception wins
        tick(0, 0, 1, 1, 32'h40,  1, 32'h80,  1,  1, 32'h84,  1, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h100, 0, 0, 0);
        // redirect while stalled with nothing outstanding
        tick(0, 1, 0, 1, 32'h200, 0, 32'h0,   1,  0, 32'h104, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h200, 0, 0, 0);
        // same-cycle redirect beats pending target
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   0,  1, 32'h204, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h300, 0, 32'h0,   0,  1, 32'h204, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   1, 32'h400, 1,  1, 32'h204, 1, 1, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h400, 0, 0, 0);
        // misaligned jump target
        tick(0, 0, 0, 1, 32'h42,  0, 32'h0,   1,  1, 32'h404, 1, 0, ALN);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, a42,     0, 0, 0);
        // wrap: 8-bit instance goes FC -> 00
        tick(0, 0, 0, 1, 32'hfc,  0, 32'h0,   1,  1, a42 + 4, 1, 0, 0);
        c8_en = 1'b1; c8_pc = 8'hfc;
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'hfc,  0, 0, 0);
        c8_pc = 8'h00;
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h100, 0, 0, 0);
        c8_en = 1'b0;
        // reset in the middle of a held request with a pending target
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   0,  1, 32'h104, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h500, 0, 32'h0,   0,  1, 32'h104, 0, 0, 0);
        tick(1, 0, 0, 0, 32'h0,   0, 32'h0,   0,  0, 32'h104, 0, 1, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  0, 32'h0,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h0,   0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 32'h0,   1,  1, 32'h4,   0, 0, 0);
        repeat (3) @(posedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
